// File: rtl/am_error_monitor.sv
// Error-statistics monitor for 8x8 approximate multipliers: compares P_APPROX
// against the exact product and accumulates ED sum/max/error count over a run.
module am_error_monitor #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned N_SAMPLES = 65536,
   parameter int unsigned CNT_W     = 17,
   parameter int unsigned SUM_W     = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   input  logic [2*WIDTH-1:0]   P_APPROX,
   output logic                 busy,
   output logic                 done,
   output logic [CNT_W-1:0]     smp_cnt,
   output logic [CNT_W-1:0]     err_cnt,
   output logic [SUM_W-1:0]     ed_sum,
   output logic [2*WIDTH-1:0]   ed_max
);

   localparam int unsigned PW = 2 * WIDTH;
   localparam int unsigned XW = ((SUM_W > PW) ? SUM_W : PW) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] acc_cnt;
   logic             v1, v2;
   logic [WIDTH-1:0] a1, b1;
   logic [PW-1:0]    p1, ed2;
   logic [PW-1:0]    exact_c, ed_c;
   logic [XW-1:0]    sum_ext;
   logic             accept, last_acc;

   assign accept   = (state == RUN) && in_valid && !start;
   assign last_acc = accept && (acc_cnt == CNT_W'(N_SAMPLES - 1));
   assign exact_c  = PW'(a1) * PW'(b1);
   assign ed_c     = (exact_c >= p1) ? (exact_c - p1) : (p1 - exact_c);
   assign sum_ext  = XW'(ed_sum) + XW'(ed2);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      in_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE:  ;
         RUN: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (last_acc) state_nx = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (!v1 && !v2) state_nx = DONE;
         end
         DONE:  done = 1'b1;
         default: state_nx = IDLE;
      endcase
      // start from any state restarts the run; it also overrides a same-edge accept
      if (start) state_nx = RUN;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1      <= 1'b0;
         v2      <= 1'b0;
         a1      <= '0;
         b1      <= '0;
         p1      <= '0;
         ed2     <= '0;
         acc_cnt <= '0;
         smp_cnt <= '0;
         err_cnt <= '0;
         ed_sum  <= '0;
         ed_max  <= '0;
      end else if (start) begin
         v1      <= 1'b0;
         v2      <= 1'b0;
         acc_cnt <= '0;
         smp_cnt <= '0;
         err_cnt <= '0;
         ed_sum  <= '0;
         ed_max  <= '0;
      end else begin
         v1 <= accept;
         if (accept) begin
            a1      <= A;
            b1      <= B;
            p1      <= P_APPROX;
            acc_cnt <= acc_cnt + CNT_W'(1);
         end
         v2 <= v1;
         if (v1) ed2 <= ed_c;
         if (v2) begin
            smp_cnt <= smp_cnt + CNT_W'(1);
            if (ed2 != '0) err_cnt <= err_cnt + CNT_W'(1);
            // any carry above SUM_W bits pins the sum at all-ones until cleared
            if (|sum_ext[XW-1:SUM_W]) ed_sum <= '1;
            else                      ed_sum <= sum_ext[SUM_W-1:0];
            if (ed2 > ed_max) ed_max <= ed2;
         end
      end
   end

endmodule
